pipe_ctrl: RTL and testbench

Central pipeline controller for the five-stage core. It merges stall requests from IF, ID and EX into the nested `stall[5:0]` vector consumed by pc_reg and every stage register (if_id, id_ex, ex_mem, mem_wb). It turns the exception type reported by the MEM stage into a `flush` pulse and a redirect `new_pc`. Exceptions that arrive while an instruction-fetch bus transaction is still in flight are held in a pending state until the bus releases.

---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/pipe_ctrl_exc_vector_dec.sv | 24 ++
 rtl/pipe_ctrl.sv | 108 ++++++++++
 tb/tb_pipe_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline controller.
package pipe_ctrl_pkg;

    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;
    localparam logic RstEnable = 1'b1;

    // Exception codes reported by the MEM stage
    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_OVERFLOW = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    // Nested stall vectors: bit0 pc .. bit5 wb
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_exc_vector_dec.sv
// Maps an exception code (and EPC for eret) to the redirect address.
module exc_vector_dec
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] INT_VECTOR = 32'h0000_0020,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
    input  logic [31:0] exc_type,
    input  logic [31:0] epc,
    output logic [31:0] new_pc
);

    // Decode: interrupts and eret are special, everything else nonzero goes to the common vector
    always_comb begin
        new_pc = 32'h0;
        case (exc_type)
            EXC_NONE: new_pc = 32'h0;
            EXC_INT:  new_pc = INT_VECTOR;
            EXC_ERET: new_pc = epc;
            default:  new_pc = EXC_VECTOR;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall requests, turns MEM exceptions into a
// one-cycle flush plus redirect, and defers exceptions behind an in-flight fetch.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] INT_VECTOR = 32'h0000_0020,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic [31:0] excepttype,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles
);

    pc_state_e   state_q, state_d;
    logic [31:0] pend_type_q, pend_type_d;
    logic [31:0] pend_epc_q, pend_epc_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] live_pc, pend_pc;

    // Live path decodes the MEM stage inputs; pend path decodes the latched exception
    exc_vector_dec #(.INT_VECTOR(INT_VECTOR), .EXC_VECTOR(EXC_VECTOR)) u_dec_live (
        .exc_type (excepttype),
        .epc      (cp0_epc),
        .new_pc   (live_pc)
    );

    exc_vector_dec #(.INT_VECTOR(INT_VECTOR), .EXC_VECTOR(EXC_VECTOR)) u_dec_pend (
        .exc_type (pend_type_q),
        .epc      (pend_epc_q),
        .new_pc   (pend_pc)
    );

    // Next-state and outputs; the fetch bus cannot be aborted so it alone defers a flush
    always_comb begin
        state_d     = state_q;
        pend_type_d = pend_type_q;
        pend_epc_d  = pend_epc_q;
        stall       = STALL_NONE;
        flush       = 1'b0;
        new_pc      = 32'h0;
        if (rst != RstEnable) begin
            case (state_q)
                RUN: begin
                    if (excepttype != EXC_NONE) begin
                        if (stallreq_if) begin
                            // Freeze everything, keeping the excepting instruction in MEM
                            stall       = STALL_ALL;
                            pend_type_d = excepttype;
                            pend_epc_d  = cp0_epc;
                            state_d     = PEND;
                        end else begin
                            flush  = 1'b1;
                            new_pc = live_pc;
                        end
                    end else begin
                        if (stallreq_if) stall = stall | STALL_IF;
                        if (stallreq_id) stall = stall | STALL_ID;
                        if (stallreq_ex) stall = stall | STALL_EX;
                    end
                end
                PEND: begin
                    if (stallreq_if) begin
                        stall = STALL_ALL;
                    end else begin
                        flush       = 1'b1;
                        new_pc      = pend_pc;
                        pend_type_d = 32'h0;
                        pend_epc_d  = 32'h0;
                        state_d     = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Stalled-cycle counter, wraps naturally at 32 bits
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall[0] == Stop) stall_cycles_d = stall_cycles_q + 32'd1;
    end

    // State, pending-exception latches and counter registers
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q        <= RUN;
            pend_type_q    <= 32'h0;
            pend_epc_q     <= 32'h0;
            stall_cycles_q <= 32'h0;
        end else begin
            state_q        <= state_d;
            pend_type_q    <= pend_type_d;
            pend_epc_q     <= pend_epc_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with hand-computed expectations.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex;
    logic [31:0] excepttype, cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc, stall_cycles;

    int n_err = 0;
    int n_chk = 0;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .excepttype   (excepttype),
        .cp0_epc      (cp0_epc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change 1ns after it, checks follow a settle delay
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic [5:0] s, input logic f, input logic [31:0] pc);
        #1;
        chk({tag, ".stall"}, {26'h0, stall}, {26'h0, s});
        chk({tag, ".flush"}, {31'h0, flush}, {31'h0, f});
        chk({tag, ".new_pc"}, new_pc, pc);
    endtask

    initial begin
        // 1: reset dominates active inputs
        rst = 1'b1; stallreq_if = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b1;
        excepttype = 32'h8; cp0_epc = 32'h0;
        tick(); tick();
        outs("rst", 6'b000000, 1'b0, 32'h0);
        chk("rst.cnt", stall_cycles, 32'd0);

        // 2: nested stalls
        rst = 1'b0; stallreq_ex = 1'b0; excepttype = 32'h0;
        tick();
        stallreq_id = 1'b1;
        outs("id", 6'b000111, 1'b0, 32'h0);
        chk("id.cnt", stall_cycles, 32'd0);
        tick();
        stallreq_ex = 1'b1; stallreq_if = 1'b1;
        outs("ex_if", 6'b001111, 1'b0, 32'h0);
        tick(); tick(); tick(); tick();
        chk("cnt5", stall_cycles, 32'd5);

        // 3: immediate exception overrides EX stall
        stallreq_id = 1'b0; stallreq_if = 1'b0; stallreq_ex = 1'b0;
        tick();
        excepttype = 32'hc; stallreq_ex = 1'b1; stallreq_id = 1'b1;
        outs("ovf", 6'b000000, 1'b1, 32'h40);
        tick();
        excepttype = 32'h0; stallreq_ex = 1'b0; stallreq_id = 1'b0;
        outs("ovf_next", 6'b000000, 1'b0, 32'h0);
        chk("ovf.cnt", stall_cycles, 32'd5);

        // 4: interrupt, eret, and an unlisted nonzero code
        excepttype = 32'h1;
        outs("int", 6'b000000, 1'b1, 32'h20);
        excepttype = 32'he; cp0_epc = 32'h0000_1234;
        outs("eret", 6'b000000, 1'b1, 32'h1234);
        excepttype = 32'h5;
        outs("other", 6'b000000, 1'b1, 32'h40);
        tick();

        // 5: exception pended behind a fetch
        excepttype = 32'he; cp0_epc = 32'h100; stallreq_if = 1'b1;
        outs("pend1", 6'b111111, 1'b0, 32'h0);
        tick();
        excepttype = 32'h0; cp0_epc = 32'h200;
        outs("pend2", 6'b111111, 1'b0, 32'h0);
        tick();
        stallreq_id = 1'b1; excepttype = 32'h1;
        outs("pend3", 6'b111111, 1'b0, 32'h0);
        tick();
        stallreq_if = 1'b0;
        outs("pend4", 6'b000000, 1'b1, 32'h100);
        tick();
        stallreq_id = 1'b0; excepttype = 32'h0;
        outs("pend5", 6'b000000, 1'b0, 32'h0);
        chk("pend.cnt", stall_cycles, 32'd8);

        // 6: reset while pending drops the exception
        excepttype = 32'h8; stallreq_if = 1'b1;
        outs("rp_enter", 6'b111111, 1'b0, 32'h0);
        tick();
        excepttype = 32'h0; rst = 1'b1;
        outs("rp_rst", 6'b000000, 1'b0, 32'h0);
        tick();
        rst = 1'b0; stallreq_if = 1'b0;
        outs("rp_after", 6'b000000, 1'b0, 32'h0);
        chk("rp.cnt0", stall_cycles, 32'd0);
        tick();
        outs("rp_after2", 6'b000000, 1'b0, 32'h0);
        chk("rp.cnt1", stall_cycles, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
